// File: rtl/nonce_sched_pkg.sv
// Shared constants, FSM encoding and the round-robin pick helper for the
// nonce uplink scheduler.
package nonce_sched_pkg;

    localparam int unsigned NONCE_W    = 32;
    localparam int unsigned MAX_LOG2   = 6;
    localparam int unsigned MAX_MINERS = 1 << MAX_LOG2;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_BUSY = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    // First requesting index searched cyclically from last+1; returns last if none.
    // Scanning downward lets the nearest requester overwrite farther ones.
    function automatic int unsigned rr_pick(input logic [MAX_MINERS-1:0] req,
                                            input int unsigned last,
                                            input int unsigned n);
        int unsigned idx;
        rr_pick = last;
        for (int unsigned k = MAX_MINERS; k >= 1; k--) begin
            if (k <= n) begin
                idx = last + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAX_LOG2-1:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/nonce_tx_scheduler_if.sv
// Miner-side nonce strobes plus uplink transmitter handshake and status.
interface nonce_tx_scheduler_if
    import nonce_sched_pkg::*;
#(
    parameter int unsigned MINERS  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned GRANT_W = (MINERS > 1) ? $clog2(MINERS) : 1
);
    logic [MINERS-1:0]         new_nonces;
    logic [MINERS*NONCE_W-1:0] slave_nonces;
    logic                      serial_busy;
    logic                      serial_send;
    logic [NONCE_W-1:0]        golden_nonce;
    logic [MINERS-1:0]         dropped;
    logic [CNT_W-1:0]          drop_count;
    logic [GRANT_W-1:0]        grant_id;

    modport slave (
        input  new_nonces, slave_nonces, serial_busy,
        output serial_send, golden_nonce, dropped, drop_count, grant_id
    );

    modport master (
        output new_nonces, slave_nonces, serial_busy,
        input  serial_send, golden_nonce, dropped, drop_count, grant_id
    );
endinterface

// File: rtl/nonce_fifo.sv
// Small synchronous show-ahead FIFO; a push while full is ignored unless a pop
// frees the slot in the same cycle.
module nonce_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_q, wr_d, rd_q, rd_d;
    logic                do_push, do_pop;

    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[DEPTH_LOG2] != rd_q[DEPTH_LOG2]) &&
                  (wr_q[DEPTH_LOG2-1:0] == rd_q[DEPTH_LOG2-1:0]);
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        wr_d    = wr_q + (DEPTH_LOG2+1)'(do_push);
        rd_d    = rd_q + (DEPTH_LOG2+1)'(do_pop);
        dout_o  = mem_q[rd_q[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= din_i;
    end
endmodule

// File: rtl/nonce_tx_scheduler.sv
// Buffers golden nonces per miner and serialises them round-robin onto the
// shared uplink transmitter (send pulse, wait busy rise, wait busy fall).
module nonce_tx_scheduler
    import nonce_sched_pkg::*;
#(
    parameter int unsigned MINERS       = 2,
    parameter int unsigned DEPTH_LOG2   = 1,
    parameter int unsigned BUSY_TIMEOUT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input logic                  hash_clk,
    input logic                  reset,
    nonce_tx_scheduler_if.slave  bus
);
    localparam int unsigned GW = (MINERS > 1) ? $clog2(MINERS) : 1;
    localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    logic [MINERS-1:0]     full, empty, pop, drop_vec;
    logic [NONCE_W-1:0]    head [MINERS];
    logic [MAX_MINERS-1:0] req;
    logic [GW-1:0]         pick;
    logic                  grant;
    logic [CNT_W:0]        drop_n, cnt_sum;

    logic [1:0]         state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               send_q, send_d;
    logic [NONCE_W-1:0] golden_q, golden_d;
    logic [GW-1:0]      grant_q, grant_d, last_q, last_d;
    logic [MINERS-1:0]  dropped_q, dropped_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    for (genvar i = 0; i < MINERS; i++) begin : g_fifo
        nonce_fifo #(.WIDTH(NONCE_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
            .clk_i   (hash_clk),
            .rst_i   (reset),
            .push_i  (bus.new_nonces[i]),
            .din_i   (bus.slave_nonces[i*NONCE_W +: NONCE_W]),
            .pop_i   (pop[i]),
            .dout_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    always_comb begin
        req = '0;
        req[MINERS-1:0] = ~empty;
        pick  = GW'(rr_pick(req, 32'(last_q), MINERS));
        grant = (state_q == IDLE) && (|(~empty)) && !bus.serial_busy;
        pop = '0;
        if (grant) pop[pick] = 1'b1;

        // A full FIFO popped this cycle accepts the push, so it is not a drop.
        drop_vec = bus.new_nonces & full & ~pop;
        drop_n   = '0;
        for (int unsigned i = 0; i < MINERS; i++) drop_n = drop_n + (CNT_W+1)'(drop_vec[i]);
        cnt_sum   = {1'b0, cnt_q} + drop_n;
        cnt_d     = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        dropped_d = dropped_q | drop_vec;

        state_d  = state_q;
        timer_d  = timer_q;
        send_d   = 1'b0;
        golden_d = golden_q;
        grant_d  = grant_q;
        last_d   = last_q;
        case (state_q)
            IDLE: if (grant) begin
                state_d  = WAIT_BUSY;
                timer_d  = '0;
                send_d   = 1'b1;
                golden_d = head[pick];
                grant_d  = pick;
                last_d   = pick;
            end
            WAIT_BUSY: begin
                if (bus.serial_busy)                       state_d = WAIT_DONE;
                else if (timer_q == TW'(BUSY_TIMEOUT - 1)) state_d = IDLE;
                else                                       timer_d = timer_q + 1'b1;
            end
            WAIT_DONE: if (!bus.serial_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            send_q    <= 1'b0;
            golden_q  <= '0;
            grant_q   <= '0;
            last_q    <= GW'(MINERS - 1);
            dropped_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            send_q    <= send_d;
            golden_q  <= golden_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            dropped_q <= dropped_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.serial_send  = send_q;
    assign bus.golden_nonce = golden_q;
    assign bus.grant_id     = grant_q;
    assign bus.dropped      = dropped_q;
    assign bus.drop_count   = cnt_q;
endmodule
